// File: rtl/alu_station_pkg.sv
// alu_station_pkg
//   Shared types and ALU op codes for the ALU reservation station and the
//   dispatch allocator that feeds it.
//   word_t    : 32-bit data word
//   regaddr_t : 5-bit architectural register address
//   regtag_t  : producer tag; UNLOCKED (0) means the operand value is valid
//   sinst_t   : 4-bit ALU op code
package alu_station_pkg;

  localparam int TAG_W_DEF = 4;

  typedef logic [31:0]          word_t;
  typedef logic [4:0]           regaddr_t;
  typedef logic [TAG_W_DEF-1:0] regtag_t;
  typedef logic [3:0]           sinst_t;

  localparam regtag_t UNLOCKED = '0;

  localparam sinst_t OP_ADD  = 4'd0;
  localparam sinst_t OP_SUB  = 4'd1;
  localparam sinst_t OP_SLL  = 4'd2;
  localparam sinst_t OP_SLT  = 4'd3;
  localparam sinst_t OP_SLTU = 4'd4;
  localparam sinst_t OP_XOR  = 4'd5;
  localparam sinst_t OP_SRL  = 4'd6;
  localparam sinst_t OP_SRA  = 4'd7;
  localparam sinst_t OP_OR   = 4'd8;
  localparam sinst_t OP_AND  = 4'd9;

endpackage

// File: rtl/alu_station_if.sv
// alu_station_if
//   Bundles the dispatch, CDB snoop, head status and result signals of the
//   ALU reservation station.
//   master : dispatch allocator / CDB side (drives dispatch + CDB, sees status/results)
//   slave  : the station itself
interface alu_station_if
  import alu_station_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) ();

  // dispatch
  logic             en_in;
  sinst_t           op_in;
  logic [TAG_W-1:0] tagx_in;
  logic [TAG_W-1:0] tagy_in;
  logic [TAG_W-1:0] tagw_in;
  word_t            datax_in;
  word_t            datay_in;
  regaddr_t         addrw_in;

  // station status
  logic             busy;
  logic [TAG_W-1:0] head_tagx;
  logic [TAG_W-1:0] head_tagy;
  logic [TAG_W-1:0] head_tagw;

  // common data bus snoop
  logic             cdb_en;
  logic [TAG_W-1:0] cdb_tag;
  word_t            cdb_data;

  // result toward the CDB arbiter
  logic             res_en;
  logic [TAG_W-1:0] res_tag;
  regaddr_t         res_addr;
  word_t            res_data;

  modport master (
    output en_in, op_in, tagx_in, tagy_in, tagw_in, datax_in, datay_in, addrw_in,
    output cdb_en, cdb_tag, cdb_data,
    input  busy, head_tagx, head_tagy, head_tagw,
    input  res_en, res_tag, res_addr, res_data
  );

  modport slave (
    input  en_in, op_in, tagx_in, tagy_in, tagw_in, datax_in, datay_in, addrw_in,
    input  cdb_en, cdb_tag, cdb_data,
    output busy, head_tagx, head_tagy, head_tagw,
    output res_en, res_tag, res_addr, res_data
  );

endinterface

// File: rtl/alu_station_alu_core.sv
// alu_core
//   Purely combinational integer ALU.
//   op     : ALU op code (codes 10..15 produce 0)
//   x, y   : operands; shifts use y[4:0] as the amount
//   result : 32-bit result, arithmetic wraps modulo 2^32
module alu_core
  import alu_station_pkg::*;
(
  input  sinst_t op,
  input  word_t  x,
  input  word_t  y,
  output word_t  result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = x + y;
      OP_SUB:  result = x - y;
      OP_SLL:  result = x << y[4:0];
      OP_SLT:  result = {31'b0, ($signed(x) < $signed(y))};
      OP_SLTU: result = {31'b0, (x < y)};
      OP_XOR:  result = x ^ y;
      OP_SRL:  result = x >> y[4:0];
      OP_SRA:  result = word_t'($signed(x) >>> y[4:0]);
      OP_OR:   result = x | y;
      OP_AND:  result = x & y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_station.sv
// alu_station
//   Reservation station plus integer execute unit.
//   clk, rst : clock, synchronous active-low reset
//   rdy      : global ready; when low all state and outputs hold
//   bus      : alu_station_if.slave
//     dispatch en_in/op_in/tag*_in/data*_in/addrw_in, status busy/head_tag*,
//     CDB snoop cdb_en/cdb_tag/cdb_data, result res_en/res_tag/res_addr/res_data
//
// Handshake: en_in is the dispatch valid and !busy is its ready; an
// instruction transfers on a posedge where rdy && en_in && !busy. If en_in
// is high while busy the instruction is dropped. res_en is a one-cycle
// pulse with no back-pressure; the arbiter must take it.
module alu_station
  import alu_station_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  alu_station_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] UNLK = TAG_W'(UNLOCKED);

  // entry storage
  logic [DEPTH-1:0] valid_q;
  sinst_t           op_q    [DEPTH];
  logic [TAG_W-1:0] tagx_q  [DEPTH];
  logic [TAG_W-1:0] tagy_q  [DEPTH];
  logic [TAG_W-1:0] tagw_q  [DEPTH];
  word_t            datax_q [DEPTH];
  word_t            datay_q [DEPTH];
  regaddr_t         addrw_q [DEPTH];

  // result registers
  logic             res_en_q;
  logic [TAG_W-1:0] res_tag_q;
  regaddr_t         res_addr_q;
  word_t            res_data_q;

  logic             busy;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [IDX_W-1:0] head_idx;
  logic             head_any;
  logic             cdb_hit;
  logic [TAG_W-1:0] in_tagx;
  logic [TAG_W-1:0] in_tagy;
  word_t            in_datax;
  word_t            in_datay;
  word_t            alu_result;

  assign busy    = &valid_q;
  assign cdb_hit = bus.cdb_en && (bus.cdb_tag != UNLK);

  // Priority encoders: walking from the top down lets the lowest index win.
  always_comb begin
    ready_vec = '0;
    free_idx  = '0;
    sel_idx   = '0;
    sel_any   = 1'b0;
    head_idx  = '0;
    head_any  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_vec[i] = valid_q[i] && (tagx_q[i] == UNLK) && (tagy_q[i] == UNLK);
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
      if (valid_q[i]) begin
        head_idx = IDX_W'(i);
        head_any = 1'b1;
      end
    end
  end

  // Same-cycle CDB bypass into the instruction being allocated.
  always_comb begin
    in_tagx  = bus.tagx_in;
    in_datax = bus.datax_in;
    in_tagy  = bus.tagy_in;
    in_datay = bus.datay_in;
    if (cdb_hit && (bus.tagx_in == bus.cdb_tag)) begin
      in_tagx  = UNLK;
      in_datax = bus.cdb_data;
    end
    if (cdb_hit && (bus.tagy_in == bus.cdb_tag)) begin
      in_tagy  = UNLK;
      in_datay = bus.cdb_data;
    end
  end

  alu_core u_alu (
    .op     (op_q[sel_idx]),
    .x      (datax_q[sel_idx]),
    .y      (datay_q[sel_idx]),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      res_en_q   <= 1'b0;
      res_tag_q  <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        tagx_q[i]  <= '0;
        tagy_q[i]  <= '0;
        tagw_q[i]  <= '0;
        datax_q[i] <= '0;
        datay_q[i] <= '0;
        addrw_q[i] <= '0;
      end
    end else if (rdy) begin
      // wakeup of waiting operands
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_hit) begin
          if (tagx_q[i] == bus.cdb_tag) begin
            tagx_q[i]  <= UNLK;
            datax_q[i] <= bus.cdb_data;
          end
          if (tagy_q[i] == bus.cdb_tag) begin
            tagy_q[i]  <= UNLK;
            datay_q[i] <= bus.cdb_data;
          end
        end
      end

      // select + execute; the issued slot is freed on this edge
      if (sel_any) begin
        valid_q[sel_idx] <= 1'b0;
        res_en_q         <= 1'b1;
        res_tag_q        <= tagw_q[sel_idx];
        res_addr_q       <= addrw_q[sel_idx];
        res_data_q       <= alu_result;
      end else begin
        res_en_q <= 1'b0;
      end

      // allocate; free_idx is an invalid slot so it never collides with sel_idx
      if (bus.en_in && !busy) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= bus.op_in;
        tagx_q[free_idx]  <= in_tagx;
        datax_q[free_idx] <= in_datax;
        tagy_q[free_idx]  <= in_tagy;
        datay_q[free_idx] <= in_datay;
        tagw_q[free_idx]  <= bus.tagw_in;
        addrw_q[free_idx] <= bus.addrw_in;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.head_tagx = head_any ? tagx_q[head_idx] : '0;
  assign bus.head_tagy = head_any ? tagy_q[head_idx] : '0;
  assign bus.head_tagw = head_any ? tagw_q[head_idx] : '0;
  assign bus.res_en    = res_en_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_addr  = res_addr_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station
//   Directed bench for alu_station: dispatch/CDB driver tasks, an expected
//   result queue filled at dispatch time and a monitor that pops it on every
//   res_en pulse, plus inline checks of status outputs and pulse timing.
module tb_alu_station;
  import alu_station_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int W     = TAG_W + 5 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  alu_station_if #(.TAG_W(TAG_W)) bus ();

  alu_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.en_in    = 1'b0;
    bus.op_in    = '0;
    bus.tagx_in  = '0;
    bus.tagy_in  = '0;
    bus.tagw_in  = '0;
    bus.datax_in = '0;
    bus.datay_in = '0;
    bus.addrw_in = '0;
    bus.cdb_en   = 1'b0;
    bus.cdb_tag  = '0;
    bus.cdb_data = '0;
  endtask

  task automatic set_dispatch(input sinst_t op, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty,
                              input logic [TAG_W-1:0] tw, input word_t dx, input word_t dy,
                              input regaddr_t aw);
    bus.en_in    = 1'b1;
    bus.op_in    = op;
    bus.tagx_in  = tx;
    bus.tagy_in  = ty;
    bus.tagw_in  = tw;
    bus.datax_in = dx;
    bus.datay_in = dy;
    bus.addrw_in = aw;
  endtask

  // Drive one dispatch for one edge; push the expected result when it will execute.
  task automatic dispatch(input sinst_t op, input logic [TAG_W-1:0] tx, input logic [TAG_W-1:0] ty,
                          input logic [TAG_W-1:0] tw, input word_t dx, input word_t dy,
                          input regaddr_t aw, input bit will_exec, input word_t exp_data);
    set_dispatch(op, tx, ty, tw, dx, dy, aw);
    if (will_exec) exp_q.push_back({tw, aw, exp_data});
    tick();
    bus.en_in = 1'b0;
  endtask

  task automatic cdb_on(input logic [TAG_W-1:0] tag, input word_t data);
    bus.cdb_en   = 1'b1;
    bus.cdb_tag  = tag;
    bus.cdb_data = data;
  endtask

  task automatic cdb_off();
    bus.cdb_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_res_en"},    32'(bus.res_en),    32'd0);
    check({tag, "_res_tag"},   32'(bus.res_tag),   32'd0);
    check({tag, "_res_addr"},  32'(bus.res_addr),  32'd0);
    check({tag, "_res_data"},  bus.res_data,       32'd0);
    check({tag, "_head_tagx"}, 32'(bus.head_tagx), 32'd0);
    check({tag, "_head_tagy"}, 32'(bus.head_tagy), 32'd0);
    check({tag, "_head_tagw"}, 32'(bus.head_tagw), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always begin
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    if (bus.res_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got tag=%0d addr=%0d data=0x%08h required no result",
                 bus.res_tag, bus.res_addr, bus.res_data);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.res_tag, bus.res_addr, bus.res_data} !== exp) begin
          errors++;
          $display("FAIL result: got tag=%0d addr=%0d data=0x%08h required tag=%0d addr=%0d data=0x%08h",
                   bus.res_tag, bus.res_addr, bus.res_data,
                   exp[W-1 -: TAG_W], exp[36:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // simple ADD, ready at dispatch
    dispatch(OP_ADD, 0, 0, 3, 32'd5, 32'd7, 5'd9, 1'b1, 32'd12);
    check("add_res_en_early", 32'(bus.res_en), 32'd0);
    check("add_busy", 32'(bus.busy), 32'd0);
    check("add_head_tagw", 32'(bus.head_tagw), 32'd3);
    tick();
    check("add_res_en", 32'(bus.res_en), 32'd1);
    check("add_busy_after", 32'(bus.busy), 32'd0);
    check("add_head_empty", 32'(bus.head_tagw), 32'd0);
    tick();

    // SUB waiting on tag 2, woken by CDB
    dispatch(OP_SUB, 2, 0, 6, 32'hDEAD_BEEF, 32'd1, 5'd10, 1'b1, 32'd9);
    check("sub_head_tagx", 32'(bus.head_tagx), 32'd2);
    check("sub_no_result", 32'(bus.res_en), 32'd0);
    tick();
    check("sub_still_waiting", 32'(bus.res_en), 32'd0);
    cdb_on(2, 32'd10);
    check("sub_head_tagx_before_wake", 32'(bus.head_tagx), 32'd2);
    tick();
    cdb_off();
    check("sub_head_tagx_woken", 32'(bus.head_tagx), 32'd0);
    check("sub_res_en_wake_edge", 32'(bus.res_en), 32'd0);
    tick();
    check("sub_res_en", 32'(bus.res_en), 32'd1);
    tick();

    // CDB bypass into the allocating entry
    cdb_on(4, 32'd31);
    dispatch(OP_SLL, 0, 4, 7, 32'd1, 32'd5, 5'd11, 1'b1, 32'h8000_0000);
    cdb_off();
    check("bypass_head_tagy", 32'(bus.head_tagy), 32'd0);
    tick();
    check("bypass_res_en", 32'(bus.res_en), 32'd1);
    tick();

    // fill all entries waiting on tag 5, then overflow
    dispatch(OP_ADD, 5, 0, 8,  32'd0, 32'd1,    5'd16, 1'b1, 32'd101);
    dispatch(OP_SUB, 5, 0, 9,  32'd0, 32'd1,    5'd17, 1'b1, 32'd99);
    dispatch(OP_XOR, 5, 0, 10, 32'd0, 32'h0FF,  5'd18, 1'b1, 32'd155);
    dispatch(OP_OR,  5, 0, 11, 32'd0, 32'd3,    5'd19, 1'b1, 32'd103);
    check("fill_busy", 32'(bus.busy), 32'd1);
    dispatch(OP_ADD, 5, 0, 15, 32'd0, 32'd0, 5'd31, 1'b0, 32'd0);
    check("drop_busy", 32'(bus.busy), 32'd1);
    check("drop_head_tagw", 32'(bus.head_tagw), 32'd8);
    cdb_on(5, 32'd100);
    tick();
    cdb_off();
    check("fill_woken_busy", 32'(bus.busy), 32'd1);
    check("fill_woken_res_en", 32'(bus.res_en), 32'd0);
    check("fill_woken_head_tagx", 32'(bus.head_tagx), 32'd0);
    tick();
    check("fill_r0_en", 32'(bus.res_en), 32'd1);
    check("fill_r0_busy", 32'(bus.busy), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("fill_rn_en", 32'(bus.res_en), 32'd1);
    end
    tick();
    check("fill_done_en", 32'(bus.res_en), 32'd0);
    check("fill_done_head", 32'(bus.head_tagw), 32'd0);

    // op corner cases, back to back
    dispatch(OP_SLT,  0, 0, 1, 32'hFFFF_FFFF, 32'd1,    5'd1, 1'b1, 32'd1);
    dispatch(OP_SLTU, 0, 0, 2, 32'hFFFF_FFFF, 32'd1,    5'd2, 1'b1, 32'd0);
    dispatch(OP_SRA,  0, 0, 3, 32'h8000_0000, 32'd4,    5'd3, 1'b1, 32'hF800_0000);
    dispatch(4'd12,   0, 0, 4, 32'd5,         32'd6,    5'd4, 1'b1, 32'd0);
    dispatch(OP_SRL,  0, 0, 5, 32'h8000_0000, 32'd4,    5'd5, 1'b1, 32'h0800_0000);
    dispatch(OP_AND,  0, 0, 6, 32'h0000_F0F0, 32'hFF00, 5'd6, 1'b1, 32'h0000_F000);
    dispatch(OP_SRA,  0, 0, 7, 32'h8000_0000, 32'd36,   5'd7, 1'b1, 32'hF800_0000);
    dispatch(OP_ADD,  0, 0, 0, 32'hFFFF_FFFF, 32'd2,    5'd8, 1'b1, 32'd1);
    wait_drain(20);
    tick();

    // freeze with rdy low: a ready entry and a waiting entry pending
    dispatch(OP_ADD, 6, 0, 10, 32'd0, 32'd1, 5'd13, 1'b0, 32'd0);
    dispatch(OP_ADD, 0, 0, 9,  32'd2, 32'd3, 5'd12, 1'b1, 32'd5);
    rdy = 1'b0;
    set_dispatch(OP_ADD, 0, 0, 14, 32'd1, 32'd1, 5'd14);
    cdb_on(6, 32'd50);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_res_en", 32'(bus.res_en), 32'd0);
    end
    check("freeze_head_tagx", 32'(bus.head_tagx), 32'd6);
    check("freeze_head_tagw", 32'(bus.head_tagw), 32'd10);
    idle_inputs();
    rdy = 1'b1;
    tick();
    check("unfreeze_res_en", 32'(bus.res_en), 32'd1);
    check("unfreeze_head_tagx", 32'(bus.head_tagx), 32'd6);

    // reset with two pending entries
    dispatch(OP_ADD, 7, 0, 11, 32'd0, 32'd1, 5'd15, 1'b0, 32'd0);
    rst = 1'b0;
    tick();
    check_all_zero("midreset");
    rst = 1'b1;
    cdb_on(6, 32'd1);
    tick();
    cdb_on(7, 32'd2);
    tick();
    cdb_off();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_res_en", 32'(bus.res_en), 32'd0);
    end
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
